// File: rtl/alu2_issue_queue.sv
// alu2_issue_queue: in-order issue queue for the ALU2 execute port.
// Holds dispatched ops in a circular buffer, snoops the writeback bus to
// fill missing sources, and issues the head once both sources are ready.
module alu2_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             iCLOCK,
  input  logic             iRESET_SYNC,
  input  logic             iFREE_EX,
  input  logic             iDISP_VALID,
  output logic             oDISP_LOCK,
  input  logic [5:0]       iDISP_COMMIT_TAG,
  input  logic [4:0]       iDISP_CMD,
  input  logic [3:0]       iDISP_AFE,
  input  logic             iDISP_SYS_REG,
  input  logic             iDISP_LOGIC,
  input  logic             iDISP_SHIFT,
  input  logic             iDISP_ADDER,
  input  logic             iDISP_WRITEBACK,
  input  logic             iDISP_SRC0_VALID,
  input  logic             iDISP_SRC1_VALID,
  input  logic [31:0]      iDISP_SRC0,
  input  logic [31:0]      iDISP_SRC1,
  input  logic [5:0]       iDISP_SRC0_REGNAME,
  input  logic [5:0]       iDISP_SRC1_REGNAME,
  input  logic             iDISP_DESTINATION_SYSREG,
  input  logic [5:0]       iDISP_DESTINATION_REGNAME,
  input  logic             iDISP_FLAGS_WRITEBACK,
  input  logic [3:0]       iDISP_FLAGS_REGNAME,
  input  logic             iWB_VALID,
  input  logic             iWB_WRITEBACK,
  input  logic             iWB_SYSREG,
  input  logic [5:0]       iWB_DESTINATION_REGNAME,
  input  logic [31:0]      iWB_DATA,
  output logic             oEX_ALU2_VALID,
  input  logic             iEX_ALU2_LOCK,
  output logic             oEX_ALU2_WRITEBACK,
  output logic [5:0]       oEX_ALU2_COMMIT_TAG,
  output logic [4:0]       oEX_ALU2_CMD,
  output logic [3:0]       oEX_ALU2_AFE,
  output logic             oEX_ALU2_SYS_REG,
  output logic             oEX_ALU2_LOGIC,
  output logic             oEX_ALU2_SHIFT,
  output logic             oEX_ALU2_ADDER,
  output logic [31:0]      oEX_ALU2_SOURCE0,
  output logic [31:0]      oEX_ALU2_SOURCE1,
  output logic             oEX_ALU2_DESTINATION_SYSREG,
  output logic [5:0]       oEX_ALU2_DESTINATION_REGNAME,
  output logic             oEX_ALU2_FLAGS_WRITEBACK,
  output logic [3:0]       oEX_ALU2_FLAGS_REGNAME,
  output logic [PTR_W:0]   oCOUNT
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic        wb;
    logic [5:0]  tag;
    logic [4:0]  cmd;
    logic [3:0]  afe;
    logic        sys_reg;
    logic        lgc;
    logic        shift;
    logic        adder;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [5:0]  src0_reg;
    logic [5:0]  src1_reg;
    logic        dst_sys;
    logic [5:0]  dst_reg;
    logic        flg_wb;
    logic [3:0]  flg_reg;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   rdy0_q, rdy1_q;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;

  entry_t             din, head;
  logic               din_r0, din_r1;
  logic               wb_en, push, pop;
  logic [DEPTH-1:0]   occ, wake0, wake1;
  logic [PTR_W-1:0]   off;

  assign wb_en      = iWB_VALID && iWB_WRITEBACK && !iWB_SYSREG;
  assign head       = mem_q[rptr_q];
  assign oDISP_LOCK = (cnt_q == CNT_FULL);
  assign oCOUNT     = cnt_q;
  assign push       = iDISP_VALID && !oDISP_LOCK && !iFREE_EX && !iRESET_SYNC;
  assign oEX_ALU2_VALID = (cnt_q != '0) && rdy0_q[rptr_q] && rdy1_q[rptr_q] &&
                          !iEX_ALU2_LOCK && !iFREE_EX && !iRESET_SYNC;
  assign pop        = oEX_ALU2_VALID;

  assign oEX_ALU2_WRITEBACK           = head.wb;
  assign oEX_ALU2_COMMIT_TAG          = head.tag;
  assign oEX_ALU2_CMD                 = head.cmd;
  assign oEX_ALU2_AFE                 = head.afe;
  assign oEX_ALU2_SYS_REG             = head.sys_reg;
  assign oEX_ALU2_LOGIC               = head.lgc;
  assign oEX_ALU2_SHIFT               = head.shift;
  assign oEX_ALU2_ADDER               = head.adder;
  assign oEX_ALU2_SOURCE0             = head.src0;
  assign oEX_ALU2_SOURCE1             = head.src1;
  assign oEX_ALU2_DESTINATION_SYSREG  = head.dst_sys;
  assign oEX_ALU2_DESTINATION_REGNAME = head.dst_reg;
  assign oEX_ALU2_FLAGS_WRITEBACK     = head.flg_wb;
  assign oEX_ALU2_FLAGS_REGNAME       = head.flg_reg;

  // Incoming entry, with a same-cycle snoop hit folded into a missing source
  always_comb begin
    din          = '0;
    din.wb       = iDISP_WRITEBACK;
    din.tag      = iDISP_COMMIT_TAG;
    din.cmd      = iDISP_CMD;
    din.afe      = iDISP_AFE;
    din.sys_reg  = iDISP_SYS_REG;
    din.lgc      = iDISP_LOGIC;
    din.shift    = iDISP_SHIFT;
    din.adder    = iDISP_ADDER;
    din.src0_reg = iDISP_SRC0_REGNAME;
    din.src1_reg = iDISP_SRC1_REGNAME;
    din.dst_sys  = iDISP_DESTINATION_SYSREG;
    din.dst_reg  = iDISP_DESTINATION_REGNAME;
    din.flg_wb   = iDISP_FLAGS_WRITEBACK;
    din.flg_reg  = iDISP_FLAGS_REGNAME;
    din_r0 = iDISP_SRC0_VALID || (wb_en && iWB_DESTINATION_REGNAME == iDISP_SRC0_REGNAME);
    din_r1 = iDISP_SRC1_VALID || (wb_en && iWB_DESTINATION_REGNAME == iDISP_SRC1_REGNAME);
    din.src0 = iDISP_SRC0_VALID ? iDISP_SRC0 : (din_r0 ? iWB_DATA : iDISP_SRC0);
    din.src1 = iDISP_SRC1_VALID ? iDISP_SRC1 : (din_r1 ? iWB_DATA : iDISP_SRC1);
  end

  // Occupancy per slot and snoop wakeup of still-missing sources
  always_comb begin
    occ   = '0;
    wake0 = '0;
    wake1 = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rptr_q;
      occ[i]   = {1'b0, off} < cnt_q;
      wake0[i] = occ[i] && !rdy0_q[i] && wb_en && (mem_q[i].src0_reg == iWB_DESTINATION_REGNAME);
      wake1[i] = occ[i] && !rdy1_q[i] && wb_en && (mem_q[i].src1_reg == iWB_DESTINATION_REGNAME);
    end
  end

  // Pointer and count next state
  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // Pointer and count registers; flush and reset both empty the queue
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iFREE_EX) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage and ready bits: push writes the tail, snoops fill sources
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      rdy0_q <= '0;
      rdy1_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (iFREE_EX) begin
      rdy0_q <= '0;
      rdy1_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wptr_q == PTR_W'(i)) begin
          mem_q[i]  <= din;
          rdy0_q[i] <= din_r0;
          rdy1_q[i] <= din_r1;
        end else begin
          if (wake0[i]) begin
            mem_q[i].src0 <= iWB_DATA;
            rdy0_q[i]     <= 1'b1;
          end
          if (wake1[i]) begin
            mem_q[i].src1 <= iWB_DATA;
            rdy1_q[i]     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu2_issue_queue.sv
// Bench for alu2_issue_queue: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_alu2_issue_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic iCLOCK = 0, iRESET_SYNC, iFREE_EX, iDISP_VALID, oDISP_LOCK;
  logic [5:0] iDISP_COMMIT_TAG; logic [4:0] iDISP_CMD; logic [3:0] iDISP_AFE;
  logic iDISP_SYS_REG, iDISP_LOGIC, iDISP_SHIFT, iDISP_ADDER, iDISP_WRITEBACK;
  logic iDISP_SRC0_VALID, iDISP_SRC1_VALID;
  logic [31:0] iDISP_SRC0, iDISP_SRC1;
  logic [5:0] iDISP_SRC0_REGNAME, iDISP_SRC1_REGNAME;
  logic iDISP_DESTINATION_SYSREG; logic [5:0] iDISP_DESTINATION_REGNAME;
  logic iDISP_FLAGS_WRITEBACK; logic [3:0] iDISP_FLAGS_REGNAME;
  logic iWB_VALID, iWB_WRITEBACK, iWB_SYSREG;
  logic [5:0] iWB_DESTINATION_REGNAME; logic [31:0] iWB_DATA;
  logic oEX_ALU2_VALID, iEX_ALU2_LOCK;
  logic oEX_ALU2_WRITEBACK; logic [5:0] oEX_ALU2_COMMIT_TAG; logic [4:0] oEX_ALU2_CMD;
  logic [3:0] oEX_ALU2_AFE; logic oEX_ALU2_SYS_REG, oEX_ALU2_LOGIC, oEX_ALU2_SHIFT, oEX_ALU2_ADDER;
  logic [31:0] oEX_ALU2_SOURCE0, oEX_ALU2_SOURCE1;
  logic oEX_ALU2_DESTINATION_SYSREG; logic [5:0] oEX_ALU2_DESTINATION_REGNAME;
  logic oEX_ALU2_FLAGS_WRITEBACK; logic [3:0] oEX_ALU2_FLAGS_REGNAME;
  logic [PTR_W:0] oCOUNT;

  alu2_issue_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iFREE_EX(iFREE_EX),
    .iDISP_VALID(iDISP_VALID), .oDISP_LOCK(oDISP_LOCK),
    .iDISP_COMMIT_TAG(iDISP_COMMIT_TAG), .iDISP_CMD(iDISP_CMD), .iDISP_AFE(iDISP_AFE),
    .iDISP_SYS_REG(iDISP_SYS_REG), .iDISP_LOGIC(iDISP_LOGIC), .iDISP_SHIFT(iDISP_SHIFT),
    .iDISP_ADDER(iDISP_ADDER), .iDISP_WRITEBACK(iDISP_WRITEBACK),
    .iDISP_SRC0_VALID(iDISP_SRC0_VALID), .iDISP_SRC1_VALID(iDISP_SRC1_VALID),
    .iDISP_SRC0(iDISP_SRC0), .iDISP_SRC1(iDISP_SRC1),
    .iDISP_SRC0_REGNAME(iDISP_SRC0_REGNAME), .iDISP_SRC1_REGNAME(iDISP_SRC1_REGNAME),
    .iDISP_DESTINATION_SYSREG(iDISP_DESTINATION_SYSREG),
    .iDISP_DESTINATION_REGNAME(iDISP_DESTINATION_REGNAME),
    .iDISP_FLAGS_WRITEBACK(iDISP_FLAGS_WRITEBACK), .iDISP_FLAGS_REGNAME(iDISP_FLAGS_REGNAME),
    .iWB_VALID(iWB_VALID), .iWB_WRITEBACK(iWB_WRITEBACK), .iWB_SYSREG(iWB_SYSREG),
    .iWB_DESTINATION_REGNAME(iWB_DESTINATION_REGNAME), .iWB_DATA(iWB_DATA),
    .oEX_ALU2_VALID(oEX_ALU2_VALID), .iEX_ALU2_LOCK(iEX_ALU2_LOCK),
    .oEX_ALU2_WRITEBACK(oEX_ALU2_WRITEBACK), .oEX_ALU2_COMMIT_TAG(oEX_ALU2_COMMIT_TAG),
    .oEX_ALU2_CMD(oEX_ALU2_CMD), .oEX_ALU2_AFE(oEX_ALU2_AFE),
    .oEX_ALU2_SYS_REG(oEX_ALU2_SYS_REG), .oEX_ALU2_LOGIC(oEX_ALU2_LOGIC),
    .oEX_ALU2_SHIFT(oEX_ALU2_SHIFT), .oEX_ALU2_ADDER(oEX_ALU2_ADDER),
    .oEX_ALU2_SOURCE0(oEX_ALU2_SOURCE0), .oEX_ALU2_SOURCE1(oEX_ALU2_SOURCE1),
    .oEX_ALU2_DESTINATION_SYSREG(oEX_ALU2_DESTINATION_SYSREG),
    .oEX_ALU2_DESTINATION_REGNAME(oEX_ALU2_DESTINATION_REGNAME),
    .oEX_ALU2_FLAGS_WRITEBACK(oEX_ALU2_FLAGS_WRITEBACK),
    .oEX_ALU2_FLAGS_REGNAME(oEX_ALU2_FLAGS_REGNAME), .oCOUNT(oCOUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  int ntests = 0, nfail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of ops ----------------
  typedef struct {
    logic wb; logic [5:0] tag; logic [4:0] cmd; logic [3:0] afe;
    logic sr, lg, sh, ad; logic [31:0] s0, s1; logic [5:0] n0, n1;
    logic r0, r1; logic ds; logic [5:0] dr; logic fw; logic [3:0] fr;
  } op_t;
  op_t mq[$];

  function automatic logic [95:0] pk(input op_t o);
    return {o.wb, o.tag, o.cmd, o.afe, o.sr, o.lg, o.sh, o.ad, o.s0, o.s1, o.ds, o.dr, o.fw, o.fr};
  endfunction

  function automatic bit snoop(input logic [5:0] rn);
    return iWB_VALID && iWB_WRITEBACK && !iWB_SYSREG && iWB_DESTINATION_REGNAME == rn;
  endfunction

  function automatic bit exp_valid();
    if (mq.size() == 0) return 0;
    return mq[0].r0 && mq[0].r1 && !iEX_ALU2_LOCK && !iFREE_EX && !iRESET_SYNC;
  endfunction

  // Model state advance on each clock edge
  always @(posedge iCLOCK) begin
    int sz; bit p; op_t n;
    if (iRESET_SYNC || iFREE_EX) mq.delete();
    else begin
      sz = mq.size();
      p = exp_valid();
      foreach (mq[k]) begin
        if (!mq[k].r0 && snoop(mq[k].n0)) begin mq[k].r0 = 1; mq[k].s0 = iWB_DATA; end
        if (!mq[k].r1 && snoop(mq[k].n1)) begin mq[k].r1 = 1; mq[k].s1 = iWB_DATA; end
      end
      if (p) void'(mq.pop_front());
      if (iDISP_VALID && sz < DEPTH) begin
        n.wb = iDISP_WRITEBACK; n.tag = iDISP_COMMIT_TAG; n.cmd = iDISP_CMD; n.afe = iDISP_AFE;
        n.sr = iDISP_SYS_REG; n.lg = iDISP_LOGIC; n.sh = iDISP_SHIFT; n.ad = iDISP_ADDER;
        n.n0 = iDISP_SRC0_REGNAME; n.n1 = iDISP_SRC1_REGNAME;
        n.r0 = iDISP_SRC0_VALID || snoop(iDISP_SRC0_REGNAME);
        n.r1 = iDISP_SRC1_VALID || snoop(iDISP_SRC1_REGNAME);
        n.s0 = iDISP_SRC0_VALID ? iDISP_SRC0 : iWB_DATA;
        n.s1 = iDISP_SRC1_VALID ? iDISP_SRC1 : iWB_DATA;
        n.ds = iDISP_DESTINATION_SYSREG; n.dr = iDISP_DESTINATION_REGNAME;
        n.fw = iDISP_FLAGS_WRITEBACK; n.fr = iDISP_FLAGS_REGNAME;
        mq.push_back(n);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge iCLOCK) begin
    bit ev;
    if (chk_en) begin
      ev = exp_valid();
      chk("m_valid", 96'(oEX_ALU2_VALID), 96'(ev));
      chk("m_count", 96'(oCOUNT), 96'(mq.size()));
      chk("m_lock", 96'(oDISP_LOCK), 96'(mq.size() == DEPTH));
      if (ev)
        chk("m_head", {oEX_ALU2_WRITEBACK, oEX_ALU2_COMMIT_TAG, oEX_ALU2_CMD, oEX_ALU2_AFE,
                       oEX_ALU2_SYS_REG, oEX_ALU2_LOGIC, oEX_ALU2_SHIFT, oEX_ALU2_ADDER,
                       oEX_ALU2_SOURCE0, oEX_ALU2_SOURCE1, oEX_ALU2_DESTINATION_SYSREG,
                       oEX_ALU2_DESTINATION_REGNAME, oEX_ALU2_FLAGS_WRITEBACK,
                       oEX_ALU2_FLAGS_REGNAME}, pk(mq[0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    iDISP_VALID = 0; iWB_VALID = 0; iWB_WRITEBACK = 0; iWB_SYSREG = 0;
    iFREE_EX = 0; iRESET_SYNC = 0;
  endtask

  task automatic nxt();
    @(posedge iCLOCK); #1; clr();
  endtask

  task automatic smp();
    @(negedge iCLOCK);
  endtask

  task automatic disp(input logic [5:0] tag, input bit v0, input logic [31:0] d0, input logic [5:0] n0,
                      input bit v1, input logic [31:0] d1, input logic [5:0] n1);
    iDISP_VALID = 1; iDISP_COMMIT_TAG = tag; iDISP_CMD = tag[4:0] ^ 5'h15; iDISP_AFE = tag[3:0] + 4'd1;
    iDISP_SYS_REG = tag[0]; iDISP_LOGIC = tag[1]; iDISP_SHIFT = tag[2]; iDISP_ADDER = tag[3];
    iDISP_WRITEBACK = ~tag[0]; iDISP_SRC0_VALID = v0; iDISP_SRC1_VALID = v1;
    iDISP_SRC0 = d0; iDISP_SRC1 = d1; iDISP_SRC0_REGNAME = n0; iDISP_SRC1_REGNAME = n1;
    iDISP_DESTINATION_SYSREG = tag[1]; iDISP_DESTINATION_REGNAME = tag ^ 6'h2A;
    iDISP_FLAGS_WRITEBACK = tag[2]; iDISP_FLAGS_REGNAME = tag[3:0] ^ 4'h9;
  endtask

  task automatic rdy(input logic [5:0] tag);
    disp(tag, 1, 32'h1000 + 32'(tag), 6'h00, 1, 32'h2000 + 32'(tag), 6'h00);
  endtask

  task automatic wb(input logic [5:0] rn, input logic [31:0] d, input bit sys);
    iWB_VALID = 1; iWB_WRITEBACK = 1; iWB_SYSREG = sys; iWB_DESTINATION_REGNAME = rn; iWB_DATA = d;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 20 && oCOUNT != 0; k++) nxt();
    chk(nm, 96'(oCOUNT), 96'd0);
  endtask

  initial begin
    #100000;
    nfail++;
    $display("FAIL timeout actual=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    clr(); iEX_ALU2_LOCK = 0;
    disp(6'h00, 0, 0, 0, 0, 0, 0); iDISP_VALID = 0;
    iWB_DESTINATION_REGNAME = 0; iWB_DATA = 0;
    iRESET_SYNC = 1;
    nxt(); chk_en = 1;
    smp();
    chk("rst_valid", 96'(oEX_ALU2_VALID), 96'd0);
    chk("rst_lock", 96'(oDISP_LOCK), 96'd0);
    chk("rst_count", 96'(oCOUNT), 96'd0);
    chk("rst_tag", 96'(oEX_ALU2_COMMIT_TAG), 96'd0);
    chk("rst_src0", 96'(oEX_ALU2_SOURCE0), 96'd0);

    // 1: ready op issues one cycle after push
    nxt(); disp(6'h05, 1, 32'h10, 0, 1, 32'h20, 0);
    smp(); chk("t1_cnt0", 96'(oCOUNT), 96'd0);
    nxt(); smp();
    chk("t1_valid", 96'(oEX_ALU2_VALID), 96'd1);
    chk("t1_src0", 96'(oEX_ALU2_SOURCE0), 96'h10);
    chk("t1_src1", 96'(oEX_ALU2_SOURCE1), 96'h20);
    chk("t1_tag", 96'(oEX_ALU2_COMMIT_TAG), 96'h05);
    chk("t1_cnt1", 96'(oCOUNT), 96'd1);
    nxt(); smp(); chk("t1_cnt_end", 96'(oCOUNT), 96'd0);

    // 2: sysreg writeback must not wake; GPR writeback does
    nxt(); disp(6'h01, 1, 32'h1, 0, 0, 32'hBAD0BAD0, 6'h0A);
    nxt(); wb(6'h0A, 32'h11111111, 1);
    smp(); chk("t2_sys_noissue", 96'(oEX_ALU2_VALID), 96'd0);
    nxt(); wb(6'h0A, 32'hDEADBEEF, 0);
    smp(); chk("t2_wb_cycle", 96'(oEX_ALU2_VALID), 96'd0);
    nxt(); smp();
    chk("t2_valid", 96'(oEX_ALU2_VALID), 96'd1);
    chk("t2_src1", 96'(oEX_ALU2_SOURCE1), 96'hDEADBEEF);
    nxt(); smp(); chk("t2_cnt_end", 96'(oCOUNT), 96'd0);

    // 3: ready younger op waits behind not-ready head
    nxt(); disp(6'h02, 0, 32'hBAD, 6'h11, 1, 32'h22, 0);
    nxt(); disp(6'h03, 1, 32'h33, 0, 1, 32'h34, 0);
    smp(); chk("t3_noissue", 96'(oEX_ALU2_VALID), 96'd0);
    nxt(); wb(6'h11, 32'hCAFEF00D, 0);
    smp(); chk("t3_blocked", 96'(oEX_ALU2_VALID), 96'd0);
    chk("t3_cnt2", 96'(oCOUNT), 96'd2);
    nxt(); smp();
    chk("t3_first_tag", 96'(oEX_ALU2_COMMIT_TAG), 96'h02);
    chk("t3_first_src0", 96'(oEX_ALU2_SOURCE0), 96'hCAFEF00D);
    nxt(); smp();
    chk("t3_second_valid", 96'(oEX_ALU2_VALID), 96'd1);
    chk("t3_second_tag", 96'(oEX_ALU2_COMMIT_TAG), 96'h03);
    nxt();

    // 4: fill to full, hold a fifth dispatch, one pop lets it in
    iEX_ALU2_LOCK = 1;
    for (int k = 0; k < 4; k++) begin rdy(6'h20 + 6'(k)); nxt(); end
    rdy(6'h24); smp();
    chk("t4_lock", 96'(oDISP_LOCK), 96'd1);
    chk("t4_cnt4", 96'(oCOUNT), 96'd4);
    nxt(); rdy(6'h24); iEX_ALU2_LOCK = 0; smp();
    chk("t4_pop_valid", 96'(oEX_ALU2_VALID), 96'd1);
    chk("t4_lock_on_pop", 96'(oDISP_LOCK), 96'd1);
    nxt(); rdy(6'h24); iEX_ALU2_LOCK = 1; smp();
    chk("t4_lock_drop", 96'(oDISP_LOCK), 96'd0);
    chk("t4_cnt3", 96'(oCOUNT), 96'd3);
    nxt(); iEX_ALU2_LOCK = 0; smp();
    chk("t4_cnt_refill", 96'(oCOUNT), 96'd4);
    chk("t4_next_head", 96'(oEX_ALU2_COMMIT_TAG), 96'h21);
    drain("t4_drain");

    // 5: execute lock holds a ready head for three cycles
    nxt(); iEX_ALU2_LOCK = 1; rdy(6'h30);
    nxt();
    for (int k = 0; k < 3; k++) begin
      smp(); chk("t5_held", 96'(oEX_ALU2_VALID), 96'd0); nxt();
    end
    iEX_ALU2_LOCK = 0; smp();
    chk("t5_release", 96'(oEX_ALU2_VALID), 96'd1);
    chk("t5_tag", 96'(oEX_ALU2_COMMIT_TAG), 96'h30);
    nxt(); smp();
    chk("t5_once", 96'(oEX_ALU2_VALID), 96'd0);
    chk("t5_cnt0", 96'(oCOUNT), 96'd0);

    // 6a: flush with a concurrent dispatch
    nxt(); iEX_ALU2_LOCK = 1;
    for (int k = 0; k < 3; k++) begin rdy(6'h38 + 6'(k)); nxt(); end
    iEX_ALU2_LOCK = 0; iFREE_EX = 1; rdy(6'h3B); smp();
    chk("t6_flush_valid", 96'(oEX_ALU2_VALID), 96'd0);
    nxt(); smp();
    chk("t6_flush_cnt", 96'(oCOUNT), 96'd0);
    chk("t6_flush_v", 96'(oEX_ALU2_VALID), 96'd0);
    nxt(); smp(); chk("t6_flush_absent", 96'(oCOUNT), 96'd0);

    // 6b: reset while a wakeup is in flight
    nxt(); disp(6'h3C, 0, 32'hBAD, 6'h15, 1, 32'h3C, 0);
    nxt(); rdy(6'h3D); nxt(); rdy(6'h3E); nxt();
    iRESET_SYNC = 1; wb(6'h15, 32'h5555AAAA, 0); rdy(6'h3F); smp();
    chk("t6_rst_valid", 96'(oEX_ALU2_VALID), 96'd0);
    nxt(); smp();
    chk("t6_rst_cnt", 96'(oCOUNT), 96'd0);
    chk("t6_rst_v", 96'(oEX_ALU2_VALID), 96'd0);
    chk("t6_rst_tag", 96'(oEX_ALU2_COMMIT_TAG), 96'd0);
    chk("t6_rst_src0", 96'(oEX_ALU2_SOURCE0), 96'd0);
    nxt(); rdy(6'h07);
    nxt(); smp();
    chk("t6_recover", 96'(oEX_ALU2_COMMIT_TAG), 96'h07);
    chk("t6_recover_v", 96'(oEX_ALU2_VALID), 96'd1);
    nxt(); smp(); chk("t6_end_cnt", 96'(oCOUNT), 96'd0);

    nxt();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
